// File: rtl/rtc_bus_sequencer.sv
// One complete multiplexed AD-bus access: address phase, turnaround gap, data phase.
// Strobes are decoded from the next state and registered so they change cleanly with the state.
module rtc_bus_sequencer #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 10,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_GAP   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata
);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, DONE
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_cnt, w_cnt_next;
    logic       r_rw;
    logic [7:0] r_addr, r_wdata;
    logic       w_rw;
    logic [7:0] w_addr, w_wdata;
    logic       r_ad_oe, r_a_d, r_cs, r_rd, r_wr, r_busy, r_done;
    logic       w_ad_oe, w_a_d, w_cs, w_rd, w_wr;
    logic [7:0] r_ad_out, w_ad_out, r_rdata;

    function automatic logic [7:0] phase_len(input state_t s);
        case (s)
            A_SETUP, D_SETUP: phase_len = 8'(T_SETUP - 1);
            A_PULSE, D_PULSE: phase_len = 8'(T_PULSE - 1);
            A_HOLD,  D_HOLD:  phase_len = 8'(T_HOLD - 1);
            GAP:              phase_len = 8'(T_GAP - 1);
            default:          phase_len = '0;
        endcase
    endfunction

    // In IDLE the request fields come straight from the inputs so the first
    // registered outputs of A_SETUP already reflect the accepted access.
    assign w_rw    = (r_state == IDLE) ? rw    : r_rw;
    assign w_addr  = (r_state == IDLE) ? addr  : r_addr;
    assign w_wdata = (r_state == IDLE) ? wdata : r_wdata;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        if (r_state == IDLE) begin
            if (req) w_next = A_SETUP;
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - 8'd1;
        end else begin
            case (r_state)
                A_SETUP: w_next = A_PULSE;
                A_PULSE: w_next = A_HOLD;
                A_HOLD:  w_next = GAP;
                GAP:     w_next = D_SETUP;
                D_SETUP: w_next = D_PULSE;
                D_PULSE: w_next = D_HOLD;
                D_HOLD:  w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
        if (w_next != r_state) w_cnt_next = phase_len(w_next);
    end

    always_comb begin
        w_cs     = 1'b1;
        w_rd     = 1'b1;
        w_wr     = 1'b1;
        w_a_d    = 1'b1;
        w_ad_oe  = 1'b0;
        w_ad_out = r_ad_out;
        case (w_next)
            A_SETUP, A_PULSE, A_HOLD: begin
                w_cs     = 1'b0;
                w_a_d    = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr;
                w_wr     = (w_next != A_PULSE);
            end
            GAP: begin
                w_ad_oe  = ~w_rw;
                w_ad_out = w_wdata;
            end
            D_SETUP, D_PULSE, D_HOLD: begin
                w_cs     = 1'b0;
                w_ad_oe  = ~w_rw;
                w_ad_out = w_wdata;
                if (w_next == D_PULSE) begin
                    w_wr = w_rw;
                    w_rd = ~w_rw;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cs     <= 1'b1;
            r_rd     <= 1'b1;
            r_wr     <= 1'b1;
            r_a_d    <= 1'b1;
            r_ad_oe  <= 1'b0;
            r_ad_out <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_rw     <= w_rw;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_cs     <= w_cs;
            r_rd     <= w_rd;
            r_wr     <= w_wr;
            r_a_d    <= w_a_d;
            r_ad_oe  <= w_ad_oe;
            r_ad_out <= w_ad_out;
            r_busy   <= (w_next != IDLE);
            r_done   <= (w_next == DONE);
            if (r_state == D_PULSE && r_cnt == '0 && r_rw)
                r_rdata <= ad_in;
        end
    end

    assign ad_out = r_ad_out;
    assign ad_oe  = r_ad_oe;
    assign a_d    = r_a_d;
    assign cs     = r_cs;
    assign rd     = r_rd;
    assign wr     = r_wr;
    assign busy   = r_busy;
    assign done   = r_done;
    assign rdata  = r_rdata;

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Generates one complete access on the RTC's multiplexed 8-bit AD bus (Intel-style, active-low strobes): an address phase, then a data phase (write or read).
- Sits directly downstream of the write-data mux/register bank. It drives a_d, cs, rd, wr and the tristate-buffer enable. It returns captured read data to the input register bank.
- The read/write control machines issue one request per RTC register access and wait for done.

Parameters:
- T_SETUP, 2, cycles AD/a_d are stable before a strobe falls (1..255)
- T_PULSE, 10, cycles a strobe (wr or rd) is held low (1..255)
- T_HOLD, 2, cycles AD/a_d are held after the strobe rises, with cs still low (1..255)
- T_GAP, 5, cycles between the address phase and the data phase with cs high; also the bus-turnaround time (1..255)

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-low reset
- req  in  1  start an access; sampled only in IDLE
- rw  in  1  1 = read, 0 = write; latched with req
- addr  in  8  RTC register address; latched with req
- wdata  in  8  write data; latched with req
- ad_in  in  8  AD bus value from the tristate buffer
- ad_out  out  8  value driven toward the AD bus
- ad_oe  out  1  tristate enable; 1 = FPGA drives AD
- a_d  out  1  0 = address phase, 1 = data phase
- cs  out  1  chip select, active low
- rd  out  1  read strobe, active low
- wr  out  1  write strobe, active low
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the access completes
- rdata  out  8  read data captured on the last read access

Behaviour:
- Reset values (applied asynchronously; an access in progress is abandoned immediately):
  - state=IDLE
  - cs=rd=wr=a_d=1
  - ad_oe=0, ad_out=0x00
  - busy=0, done=0, rdata=0x00
  - internal counter=0
- Request acceptance:
  - At a rising edge where state=IDLE and req=1: latch rw/addr/wdata, load the counter with T_SETUP-1, enter A_SETUP.
  - req in any other state is ignored, not queued.
- States and outputs (cs/rd/wr active low; each phase lasts its parameter count in cycles):
  - A_SETUP (T_SETUP): a_d=0, cs=0, ad_oe=1, ad_out=addr
  - A_PULSE (T_PULSE): same as A_SETUP, plus wr=0
  - A_HOLD (T_HOLD): same as A_SETUP, wr=1
  - GAP (T_GAP): cs=1, a_d=1. For a write, ad_oe=1 and ad_out=wdata. For a read, ad_oe=0 (turnaround).
  - D_SETUP (T_SETUP): cs=0, a_d=1. ad_oe=~rw; ad_out=wdata for a write.
  - D_PULSE (T_PULSE): same as D_SETUP, plus wr=0 for a write or rd=0 for a read.
  - D_HOLD (T_HOLD): strobes high, cs=0, ad_oe unchanged.
  - DONE (1 cycle): done=1, cs=1, ad_oe=0, a_d=1. Next state is IDLE.
- Counter: a single down-counter. When it reaches 0, advance to the next state and reload with that state's parameter minus 1.
- Read capture: rdata <= ad_in at the last D_PULSE cycle (counter=0 with rd still low). On writes, rdata is unchanged.
- Latency:
  - From the accepting edge to the done cycle: 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP cycles. Defaults: 33.
  - Minimum request-to-request period: that value + 2 (DONE + IDLE). Defaults: 35.
- Glitch-free strobes: cs, rd, wr, a_d, ad_oe are registered outputs.
- Strobe timing rules:
  - wr/rd never fall in the same cycle as cs falls.
  - wr/rd never rise in the same cycle as cs rises (guaranteed because T_SETUP, T_HOLD >= 1).
- Outputs driven during access: ad_out is held at the latched values throughout, so input changes during busy do not affect the bus.
- busy stays high through DONE; it falls at the edge that enters IDLE.

Test Plan:
- Write, defaults: req, rw=0, addr=0x21, wdata=0x42.
  - -> AD=0x21 with a_d=0 while wr is low for 10 cycles.
  - -> Then AD=0x42 with a_d=1 while wr is low for 10 cycles.
  - -> done pulses at the 33rd cycle after acceptance. rd never goes low. rdata is unchanged.
- Read, defaults: addr=0xF0, ad_in=0x5A during D_PULSE.
  - -> ad_oe=0 from GAP through DONE. rd is low for 10 cycles. wr stays high in the data phase.
  - -> rdata=0x5A at done.
- Busy ignore: a second req (addr=0x33) 5 cycles after the first.
  - -> Only one access occurs, with addr unchanged at 0x21.
  - -> A req issued in the first IDLE cycle after done is accepted.
- Reset mid-op: rst=0 during D_PULSE of a write.
  - -> Same cycle: wr=cs=1, ad_oe=0, busy=0.
  - -> After release, a new req completes normally.
- Minimum parameters (all =1):
  - -> Access completes in 7 cycles. Each phase lasts exactly 1 cycle.
  - -> The done-to-done period for back-to-back requests is 9 cycles.
